seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps each instruction through fetch, decode, execute, memory, write-back and PC update, and raises the per-stage enables that the fetch, decode/register-file, ALU, data-memory and PC blocks consume. It latches icode, handles the data-memory ready handshake with a timeout, and tracks processor status (AOK/HLT/ADR/INS).

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEMORY waiting for mem_ready before an ADR fault (range 1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin execution; sampled only in IDLE
icode  in  4  instruction code from fetch; sampled on the last cycle of FETCH
imem_error  in  1  instruction-memory fault; sampled during FETCH
dmem_error  in  1  data-memory fault; sampled during MEMORY when mem_ready=1
mem_ready  in  1  data-memory completion strobe
f_en  out  1  fetch enable
d_en  out  1  decode / register-read enable
e_en  out  1  execute enable
m_req  out  1  data-memory request, held until accepted
w_en  out  1  register-file write enable
pc_en  out  1  PC update enable
cur_state  out  3  current state encoding
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy  out  1  high in every state except IDLE and HALT
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, stat=1 (AOK), instr_count=0, wait counter=0, latched icode=0; every enable output = 0; busy=0. Reset wins over every other event, including mid-instruction and while in HALT.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
- Output timing: all stage outputs are Moore outputs decoded from the state register.
  - f_en=1 only in FETCH; d_en=1 only in DECODE; e_en=1 only in EXECUTE; pc_en=1 only in PCUPD.
  - m_req=1 for every cycle spent in MEMORY.
  - w_en=1 in WRITEBACK only when the latched icode is in {2,3,5,6,8,9,A,B}.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH (1 cycle): latch icode. Checks in priority order:
  - imem_error=1 -> HALT, stat=3.
  - icode > 4'hB -> HALT, stat=4.
  - icode==0 -> HALT, stat=2.
  - Otherwise -> DECODE.
- DECODE -> EXECUTE (1 cycle).
- EXECUTE (1 cycle): icode in {4,5,8,9,A,B} -> MEMORY; otherwise -> WRITEBACK.
- MEMORY: wait counter clears on entry and increments each cycle mem_ready=0.
  - mem_ready=1 and dmem_error=1 -> HALT, stat=3; no write-back occurs.
  - mem_ready=1 and dmem_error=0 -> WRITEBACK.
  - mem_ready=0 and counter reaches MEM_TIMEOUT-1 -> HALT, stat=3.
  - Ready arriving in the same cycle as the timeout counts as success.
- WRITEBACK -> PCUPD (1 cycle).
- PCUPD (1 cycle): instr_count increments, saturating at all-ones; then -> FETCH (auto-run).
- HALT: sticky. start is ignored; stat holds; only rst exits.
- Latency:
  - Non-memory instruction: 5 cycles FETCH..PCUPD.
  - Memory instruction: 6 cycles plus wait cycles.
  - stat changes only on the HALT transition edge.
- start asserted outside IDLE is ignored.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined: PCUPD -> IDLE instead of FETCH; each start pulse in IDLE executes exactly one instruction; busy=0 between instructions.
- Undefined: continuous execution as described in Behaviour; PCUPD always -> FETCH.

Test Plan:
- Reset, start=1 for 1 cycle, icode=6 (OPq) every fetch -> f,d,e,w,pc enables each pulse for 1 cycle in order; 5 cycles per instruction; instr_count=2 after 10 cycles; m_req never high.
- icode=5 (mrmovq), mem_ready asserted 3 cycles after MEMORY entry -> m_req high for 4 cycles, then w_en=1 for 1 cycle; instr_count +1; stat=1.
- icode=4 (rmmovq), mem_ready held 0 -> HALT after 15 MEMORY cycles; stat=3; w_en never asserted; busy=0.
- icode=0 -> HALT right after FETCH with stat=2. Separately, icode=4'hC -> stat=4. Separately, imem_error=1 together with icode=0 -> stat=3 (imem_error has priority).
- Assert rst during MEMORY with m_req=1 -> next cycle state=0, all enables 0, stat=1, instr_count=0. start while in HALT -> no change.
- With SEQ_SINGLE_STEP_EN: two start pulses with icode=1 -> exactly 2 retired instructions; state returns to IDLE(0) after each PCUPD.

Source files
------------

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: stage enables, icode latch, memory wait/timeout, status.
// Optional build macro SEQ_SINGLE_STEP_EN: return to IDLE after each PCUPD so each start runs one instruction.
module seq_stage_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_req,
  output logic             w_en,
  output logic             pc_en,
  output logic [2:0]       cur_state,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WRBACK  = 3'd5,
    S_PCUPD   = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [2:0] stat_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic [3:0] icode_q, icode_nx;
  logic       retire;
  logic       is_mem_op;
  logic       writes_reg;

  assign is_mem_op  = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign writes_reg = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};

  // NOTE: non-blocking assignments here so every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      stat        <= STAT_AOK;
      wait_cnt    <= 8'd0;
      icode_q     <= 4'h0;
      instr_count <= '0;
    end else begin
      state    <= state_nx;
      stat     <= stat_nx;
      wait_cnt <= wait_nx;
      icode_q  <= icode_nx;
      if (retire && !(&instr_count))
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_nx = state;
    stat_nx  = stat;
    wait_nx  = wait_cnt;
    icode_nx = icode_q;
    retire   = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = S_FETCH;
      S_FETCH: begin
        icode_nx = icode;
        if (imem_error) begin
          state_nx = S_HALT;
          stat_nx  = STAT_ADR;
        end else if (icode > 4'hB) begin
          state_nx = S_HALT;
          stat_nx  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_nx = S_HALT;
          stat_nx  = STAT_HLT;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: begin
        if (is_mem_op) begin
          state_nx = S_MEMORY;
          wait_nx  = 8'd0;
        end else begin
          state_nx = S_WRBACK;
        end
      end
      S_MEMORY: begin
        // Ready is checked before the timeout so a late completion still succeeds.
        if (mem_ready) begin
          if (dmem_error) begin
            state_nx = S_HALT;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx = S_WRBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_HALT;
          stat_nx  = STAT_ADR;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      S_WRBACK:  state_nx = S_PCUPD;
      S_PCUPD: begin
        retire = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        state_nx = S_IDLE;
`else
        state_nx = S_FETCH;
`endif
      end
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign f_en      = (state == S_FETCH);
  assign d_en      = (state == S_DECODE);
  assign e_en      = (state == S_EXECUTE);
  assign m_req     = (state == S_MEMORY);
  assign w_en      = (state == S_WRBACK) && writes_reg;
  assign pc_en     = (state == S_PCUPD);
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign cur_state = state;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed self-checking bench for seq_stage_controller; counter width reduced to 3 to reach saturation quickly.
module tb_seq_stage_controller;

  localparam int TB_CNT_W = 3;

  logic                clk = 1'b0;
  logic                rst, start, imem_error, dmem_error, mem_ready;
  logic [3:0]          icode;
  logic                f_en, d_en, e_en, m_req, w_en, pc_en, busy;
  logic [2:0]          cur_state, stat;
  logic [TB_CNT_W-1:0] instr_count;
  logic [5:0]          en;

  int total = 0;
  int bad   = 0;

  seq_stage_controller #(.MEM_TIMEOUT(15), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ready(mem_ready),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_req(m_req), .w_en(w_en), .pc_en(pc_en),
    .cur_state(cur_state), .stat(stat), .busy(busy), .instr_count(instr_count)
  );

  assign en = {f_en, d_en, e_en, m_req, w_en, pc_en};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; icode = 4'h0;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  // Runs from IDLE through FETCH, DECODE, EXECUTE into MEMORY for a memory icode.
  task automatic go_to_memory(input logic [3:0] ic);
    start = 1'b1; icode = ic;
    tick; start = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; icode = 4'h6;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ready = 1'b0;
    tick;
    total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", cur_state); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL reset_stat: got %0d expected 1", stat); end
    total++; if (instr_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    total++; if (en !== 6'b0) begin bad++; $display("FAIL reset_enables: got %b expected 000000", en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0;
    tick;
    total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL idle_hold: got %0d expected 0", cur_state); end
  endtask

  task automatic test_opq;
    logic [2:0] st_tab [10];
    logic [5:0] en_tab [10];
    st_tab = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    en_tab = '{6'b100000, 6'b010000, 6'b001000, 6'b000010, 6'b000001,
               6'b100000, 6'b010000, 6'b001000, 6'b000010, 6'b000001};
    do_reset;
    start = 1'b1; icode = 4'h6;
    tick; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++; if (cur_state !== st_tab[i]) begin bad++; $display("FAIL opq_state[%0d]: got %0d expected %0d", i, cur_state, st_tab[i]); end
      total++; if (en !== en_tab[i]) begin bad++; $display("FAIL opq_enables[%0d]: got %b expected %b", i, en, en_tab[i]); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL opq_busy[%0d]: got %b expected 1", i, busy); end
      tick;
    end
    total++; if (instr_count !== 3'd2) begin bad++; $display("FAIL opq_count: got %0d expected 2", instr_count); end
    total++; if (cur_state !== 3'd1) begin bad++; $display("FAIL opq_autorun: got %0d expected 1", cur_state); end
  endtask

  task automatic test_mem_wait;
    do_reset;
    go_to_memory(4'h5);
    for (int i = 0; i < 4; i++) begin
      total++; if (cur_state !== 3'd4) begin bad++; $display("FAIL mem_state[%0d]: got %0d expected 4", i, cur_state); end
      total++; if (en !== 6'b000100) begin bad++; $display("FAIL mem_enables[%0d]: got %b expected 000100", i, en); end
      mem_ready = (i == 3);
      tick;
    end
    mem_ready = 1'b0;
    total++; if (cur_state !== 3'd5) begin bad++; $display("FAIL mem_wb_state: got %0d expected 5", cur_state); end
    total++; if (en !== 6'b000010) begin bad++; $display("FAIL mem_wb_enables: got %b expected 000010", en); end
    tick;
    total++; if (en !== 6'b000001) begin bad++; $display("FAIL mem_pc_enables: got %b expected 000001", en); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL mem_stat: got %0d expected 1", stat); end
    tick;
    total++; if (instr_count !== 3'd1) begin bad++; $display("FAIL mem_count: got %0d expected 1", instr_count); end
  endtask

  task automatic test_timeout;
    do_reset;
    go_to_memory(4'h4);
    for (int i = 0; i < 15; i++) begin
      total++; if (cur_state !== 3'd4) begin bad++; $display("FAIL to_state[%0d]: got %0d expected 4", i, cur_state); end
      total++; if (w_en !== 1'b0) begin bad++; $display("FAIL to_wen[%0d]: got %b expected 0", i, w_en); end
      tick;
    end
    total++; if (cur_state !== 3'd7) begin bad++; $display("FAIL to_halt: got %0d expected 7", cur_state); end
    total++; if (stat !== 3'd3) begin bad++; $display("FAIL to_stat: got %0d expected 3", stat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b expected 0", busy); end
    total++; if (en !== 6'b0) begin bad++; $display("FAIL to_enables: got %b expected 000000", en); end
    start = 1'b1;
    tick; tick;
    start = 1'b0;
    total++; if (cur_state !== 3'd7) begin bad++; $display("FAIL halt_sticky: got %0d expected 7", cur_state); end
    total++; if (stat !== 3'd3) begin bad++; $display("FAIL halt_stat_hold: got %0d expected 3", stat); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL halt_reset_state: got %0d expected 0", cur_state); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL halt_reset_stat: got %0d expected 1", stat); end
  endtask

  task automatic test_ready_at_timeout;
    do_reset;
    go_to_memory(4'h5);
    for (int i = 0; i < 15; i++) begin
      mem_ready = (i == 14);
      tick;
    end
    mem_ready = 1'b0;
    total++; if (cur_state !== 3'd5) begin bad++; $display("FAIL late_ready_state: got %0d expected 5", cur_state); end
    total++; if (w_en !== 1'b1) begin bad++; $display("FAIL late_ready_wen: got %b expected 1", w_en); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL late_ready_stat: got %0d expected 1", stat); end
  endtask

  task automatic test_dmem_error;
    do_reset;
    go_to_memory(4'h5);
    mem_ready = 1'b1; dmem_error = 1'b1;
    tick;
    mem_ready = 1'b0; dmem_error = 1'b0;
    total++; if (cur_state !== 3'd7) begin bad++; $display("FAIL dmem_state: got %0d expected 7", cur_state); end
    total++; if (stat !== 3'd3) begin bad++; $display("FAIL dmem_stat: got %0d expected 3", stat); end
    total++; if (w_en !== 1'b0) begin bad++; $display("FAIL dmem_wen: got %b expected 0", w_en); end
  endtask

  task automatic test_fetch_faults;
    logic       err_tab [5];
    logic [3:0] ic_tab  [5];
    logic [2:0] st_tab  [5];
    logic [2:0] sa_tab  [5];
    err_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ic_tab  = '{4'h0, 4'hC, 4'h0, 4'hB, 4'hF};
    st_tab  = '{3'd7, 3'd7, 3'd7, 3'd2, 3'd7};
    sa_tab  = '{3'd2, 3'd4, 3'd3, 3'd1, 3'd4};
    for (int i = 0; i < 5; i++) begin
      do_reset;
      start = 1'b1; icode = ic_tab[i]; imem_error = err_tab[i];
      tick; start = 1'b0;
      tick;
      imem_error = 1'b0;
      total++; if (cur_state !== st_tab[i]) begin bad++; $display("FAIL fetch_state[%0d]: got %0d expected %0d", i, cur_state, st_tab[i]); end
      total++; if (stat !== sa_tab[i]) begin bad++; $display("FAIL fetch_stat[%0d]: got %0d expected %0d", i, stat, sa_tab[i]); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    start = 1'b1; icode = 4'h6;
    tick; start = 1'b0;
    repeat (5) tick;
    icode = 4'h5;
    tick; tick; tick;
    total++; if (m_req !== 1'b1) begin bad++; $display("FAIL mid_mreq: got %b expected 1", m_req); end
    total++; if (instr_count !== 3'd1) begin bad++; $display("FAIL mid_count_pre: got %0d expected 1", instr_count); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL mid_rst_state: got %0d expected 0", cur_state); end
    total++; if (en !== 6'b0) begin bad++; $display("FAIL mid_rst_enables: got %b expected 000000", en); end
    total++; if (stat !== 3'd1) begin bad++; $display("FAIL mid_rst_stat: got %0d expected 1", stat); end
    total++; if (instr_count !== 3'd0) begin bad++; $display("FAIL mid_rst_count: got %0d expected 0", instr_count); end
  endtask

  task automatic test_saturation;
    do_reset;
    start = 1'b1; icode = 4'h6;
    tick; start = 1'b0;
    repeat (30) tick;
    total++; if (instr_count !== 3'd6) begin bad++; $display("FAIL sat_count6: got %0d expected 6", instr_count); end
    repeat (5) tick;
    total++; if (instr_count !== 3'd7) begin bad++; $display("FAIL sat_count7: got %0d expected 7", instr_count); end
    repeat (10) tick;
    total++; if (instr_count !== 3'd7) begin bad++; $display("FAIL sat_hold: got %0d expected 7", instr_count); end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step;
    do_reset;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; icode = 4'h1;
      tick; start = 1'b0;
      repeat (5) tick;
      total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL step_state[%0d]: got %0d expected 0", k, cur_state); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL step_busy[%0d]: got %b expected 0", k, busy); end
      total++; if (instr_count !== 3'(k + 1)) begin bad++; $display("FAIL step_count[%0d]: got %0d expected %0d", k, instr_count, k + 1); end
      tick;
      total++; if (cur_state !== 3'd0) begin bad++; $display("FAIL step_idle_hold[%0d]: got %0d expected 0", k, cur_state); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_opq;
    test_mem_wait;
    test_timeout;
    test_ready_at_timeout;
    test_dmem_error;
    test_fetch_faults;
    test_reset_mid;
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step;
`else
    test_saturation;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
